pcie_tx_arbiter: RTL and testbench
==================================

Name: pcie_tx_arbiter

Overview:
- Shares the PCIe endpoint's 64-bit AXI-Stream TX port (s_axis_tx_*) between NREQ TLP sources, e.g. MMIO read-completion generator and DMA/interrupt TLP builder.
- Grants are round-robin at whole-TLP granularity; the output is locked to one requester until tlast.
- Gates new TLP starts on core buffer availability (tx_buf_av).
- Yields idle slots to core-internal config TLPs via tx_cfg_req/tx_cfg_gnt.

Parameters:
- NREQ, 2, number of requesters (2..8).
- DATA_W, 64, TX data width in bits.
- KEEP_W, 8, DATA_W/8.
- BUF_AV_MIN, 2, minimum tx_buf_av needed to start a TLP.

Ports:
- user_clk  in  1  PCIe user clock; all logic on rising edge.
- sys_rst_n  in  1  synchronous, active-low reset.
- req_tdata  in  NREQ*DATA_W  per-requester data; slice i at [i*DATA_W +: DATA_W].
- req_tkeep  in  NREQ*KEEP_W  per-requester byte enables.
- req_tlast  in  NREQ  end of TLP.
- req_tuser  in  NREQ*4  {src_dsc, str, err_fwd, ecrc_gen}.
- req_tvalid  in  NREQ  beat valid; held from the first beat of a TLP to its tlast.
- req_tready  out  NREQ  beat accepted.
- s_axis_tx_tdata  out  DATA_W  to core.
- s_axis_tx_tkeep  out  KEEP_W  to core.
- s_axis_tx_tlast  out  1  to core.
- s_axis_tx_tuser  out  4  to core.
- s_axis_tx_tvalid  out  1  to core.
- s_axis_tx_tready  in  1  from core.
- tx_buf_av  in  6  core free TX buffers.
- tx_cfg_req  in  1  core wants to send a config TLP.
- tx_cfg_gnt  out  1  permission for core config TLP.
- tlp_cnt  out  32  TLPs completed (wraps).
- busy  out  1  arbiter locked to a requester.

Behaviour:
- Reset (sys_rst_n=0 at a rising edge):
  - state=IDLE, rr_ptr=0, grant=0, tlp_cnt=0.
  - All outputs 0 from the next cycle.
  - A TLP in flight is abandoned; no further beats are forwarded.
- States: IDLE, CFG, XFER.
- IDLE:
  - If tx_cfg_req=1, go to CFG. Config has priority over requesters.
  - Else if any req_tvalid=1 and tx_buf_av>=BUF_AV_MIN:
    - grant = first requester with req_tvalid=1 scanning rr_ptr, rr_ptr+1, ... mod NREQ.
    - Register grant; go to XFER.
  - Else stay in IDLE.
- CFG:
  - tx_cfg_gnt=1. It is registered and asserted only in CFG.
  - Return to IDLE on the cycle tx_cfg_req=0.
- XFER (combinational passthrough of the granted slice):
  - s_axis_tx_{tdata,tkeep,tlast,tuser,tvalid} = req_*[grant].
  - req_tready[i] = (i==grant) & s_axis_tx_tready. All others are 0.
  - tx_cfg_req is ignored until the TLP ends.
- End of TLP:
  - A beat with s_axis_tx_tvalid & s_axis_tx_tready & s_axis_tx_tlast ends it.
  - Next state IDLE; rr_ptr = (grant+1) mod NREQ; tlp_cnt += 1 (0xFFFFFFFF wraps to 0).
  - There is a mandatory 1-cycle IDLE bubble between TLPs.
- Outside XFER: every req_tready=0 and s_axis_tx_tvalid=0.
- Output data is don't-care when tvalid=0; the implementation drives 0.
- busy=1 exactly in XFER.
- Latency: first beat appears on s_axis_tx one cycle after the IDLE decision cycle. There is zero added latency per beat within a TLP.
- Boundary conditions:
  - Single-beat TLP (tlast on the first beat): one XFER cycle if tready=1.
  - tready low: the beat holds and the state stays XFER indefinitely. There is no timeout.
  - tx_buf_av drops below BUF_AV_MIN mid-TLP: no effect. The check applies only at TLP start.
  - tx_cfg_req and req_tvalid rise in the same IDLE cycle: CFG wins and rr_ptr is unchanged.
  - Only one requester valid: it is granted regardless of rr_ptr.
  - rr_ptr=NREQ-1: wraps to 0.

Decomposition:
- Package pcie_tx_pkg holds:
  - enum arb_state_t {IDLE, CFG, XFER};
  - localparams TUSER_W=4 and BUF_AV_W=6;
  - function next_rr(ptr, n).
- Sub-module rr_pick (combinational): inputs req[NREQ] and rr_ptr; outputs gnt_idx and any.
- The FSM, counter and mux stay in pcie_tx_arbiter.

Test Plan:
- Reset: hold sys_rst_n=0 for 100 cycles with req_tvalid=2'b11 -> every output stays 0 and tlp_cnt=0. After release, req0 (rr_ptr=0) is granted first.
- Contention: both requesters each stream 3-beat TLPs continuously with tready=1 -> grant sequence 0,1,0,1. Each TLP takes 3 XFER cycles plus 1 bubble. After 4 TLPs, tlp_cnt=4.
- Backpressure: tready toggles 1,0,0,1 during a 4-beat TLP from req1 -> s_axis_tx_tdata equals the req1 beats in order with no duplicates or drops. req_tready[0] stays 0 throughout.
- Buffer gate: tx_buf_av=1 with BUF_AV_MIN=2 and req0 valid -> stays IDLE for 10 cycles. Raising tx_buf_av to 2 gives busy=1 on the next cycle.
- Config priority: tx_cfg_req rises mid-TLP -> tx_cfg_gnt=0 until tlast is accepted, then 1 two cycles later. Holding tx_cfg_req and req0 valid in IDLE -> CFG first, req0 after tx_cfg_req falls.
- Reset mid-TLP: assert sys_rst_n=0 on beat 2 of a 4-beat TLP -> s_axis_tx_tvalid=0 next cycle, state=IDLE, tlp_cnt=0.

Source files
------------

// File: rtl/pcie_tx_pkg.sv
// rtl/pcie_tx_pkg.sv - shared types, widths and helpers for the PCIe TX arbiter
package pcie_tx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CFG  = 2'd1,
        XFER = 2'd2
    } arb_state_t;

    localparam int TUSER_W  = 4;
    localparam int BUF_AV_W = 6;

    // Round-robin successor: the requester after ptr, wrapping at n.
    function automatic int next_rr(input int ptr, input int n);
        return (ptr + 1 >= n) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/pcie_tx_arbiter_rr_pick.sv
// rtl/pcie_tx_arbiter_rr_pick.sv - combinational round-robin pick starting at rr_ptr
module rr_pick #(
    parameter int NREQ  = 2,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             any
);

    int best_off;
    int off;

    // Choose the asserted request with the smallest distance from rr_ptr.
    always_comb begin
        gnt_idx  = '0;
        best_off = NREQ;
        off      = 0;
        for (int j = 0; j < NREQ; j++) begin
            off = (j - int'(rr_ptr) + NREQ) % NREQ;
            if (req[j] && (off < best_off)) begin
                best_off = off;
                gnt_idx  = IDX_W'(j);
            end
        end
        any = |req;
    end

endmodule

// File: rtl/pcie_tx_arbiter.sv
// rtl/pcie_tx_arbiter.sv - whole-TLP round-robin arbiter onto the core TX stream
module pcie_tx_arbiter
    import pcie_tx_pkg::*;
#(
    parameter int NREQ       = 2,
    parameter int DATA_W     = 64,
    parameter int KEEP_W     = 8,
    parameter int BUF_AV_MIN = 2
) (
    input  logic                      user_clk,
    input  logic                      sys_rst_n,
    input  logic [NREQ*DATA_W-1:0]    req_tdata,
    input  logic [NREQ*KEEP_W-1:0]    req_tkeep,
    input  logic [NREQ-1:0]           req_tlast,
    input  logic [NREQ*TUSER_W-1:0]   req_tuser,
    input  logic [NREQ-1:0]           req_tvalid,
    output logic [NREQ-1:0]           req_tready,
    output logic [DATA_W-1:0]         s_axis_tx_tdata,
    output logic [KEEP_W-1:0]         s_axis_tx_tkeep,
    output logic                      s_axis_tx_tlast,
    output logic [TUSER_W-1:0]        s_axis_tx_tuser,
    output logic                      s_axis_tx_tvalid,
    input  logic                      s_axis_tx_tready,
    input  logic [BUF_AV_W-1:0]       tx_buf_av,
    input  logic                      tx_cfg_req,
    output logic                      tx_cfg_gnt,
    output logic [31:0]               tlp_cnt,
    output logic                      busy
);

    localparam int IDX_W = $clog2(NREQ);

    arb_state_t       state;
    arb_state_t       state_nxt;
    logic [IDX_W-1:0] grant;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic             buf_ok;
    logic             tlp_end;

    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req     (req_tvalid),
        .rr_ptr  (rr_ptr),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    assign buf_ok  = (tx_buf_av >= BUF_AV_W'(BUF_AV_MIN));
    assign tlp_end = (state == XFER) && s_axis_tx_tvalid && s_axis_tx_tready && s_axis_tx_tlast;
    assign busy    = (state == XFER);

    // Next-state: config wins over requesters in IDLE; a TLP, once started, runs to tlast.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (tx_cfg_req) begin
                    state_nxt = CFG;
                end else if (pick_any && buf_ok) begin
                    state_nxt = XFER;
                end
            end
            CFG: begin
                if (!tx_cfg_req) begin
                    state_nxt = IDLE;
                end
            end
            XFER: begin
                if (tlp_end) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, grant latch, round-robin pointer, TLP counter and registered config grant.
    always_ff @(posedge user_clk) begin
        if (!sys_rst_n) begin
            state      <= IDLE;
            grant      <= '0;
            rr_ptr     <= '0;
            tlp_cnt    <= '0;
            tx_cfg_gnt <= 1'b0;
        end else begin
            state      <= state_nxt;
            tx_cfg_gnt <= (state_nxt == CFG);
            if ((state == IDLE) && (state_nxt == XFER)) begin
                grant <= pick_idx;
            end
            if (tlp_end) begin
                rr_ptr  <= IDX_W'(next_rr(int'(grant), NREQ));
                tlp_cnt <= tlp_cnt + 32'd1;
            end
        end
    end

    // Passthrough of the granted slice while in XFER; everything quiet otherwise.
    always_comb begin
        s_axis_tx_tdata  = '0;
        s_axis_tx_tkeep  = '0;
        s_axis_tx_tlast  = 1'b0;
        s_axis_tx_tuser  = '0;
        s_axis_tx_tvalid = 1'b0;
        req_tready       = '0;
        if (state == XFER) begin
            for (int i = 0; i < NREQ; i++) begin
                if (grant == IDX_W'(i)) begin
                    s_axis_tx_tdata  = req_tdata[i*DATA_W +: DATA_W];
                    s_axis_tx_tkeep  = req_tkeep[i*KEEP_W +: KEEP_W];
                    s_axis_tx_tlast  = req_tlast[i];
                    s_axis_tx_tuser  = req_tuser[i*TUSER_W +: TUSER_W];
                    s_axis_tx_tvalid = req_tvalid[i];
                    req_tready[i]    = s_axis_tx_tready;
                end
            end
        end
    end

endmodule

// File: tb/tb_pcie_tx_arbiter.sv
// tb/tb_pcie_tx_arbiter.sv - self-checking bench for pcie_tx_arbiter
module tb_pcie_tx_arbiter;

    localparam int N = 2;

    logic            clk = 1'b0;
    logic            sys_rst_n;
    logic [N*64-1:0] req_tdata;
    logic [N*8-1:0]  req_tkeep;
    logic [N-1:0]    req_tlast;
    logic [N*4-1:0]  req_tuser;
    logic [N-1:0]    req_tvalid;
    logic [N-1:0]    req_tready;
    logic [63:0]     s_axis_tx_tdata;
    logic [7:0]      s_axis_tx_tkeep;
    logic            s_axis_tx_tlast;
    logic [3:0]      s_axis_tx_tuser;
    logic            s_axis_tx_tvalid;
    logic            s_axis_tx_tready;
    logic [5:0]      tx_buf_av;
    logic            tx_cfg_req;
    logic            tx_cfg_gnt;
    logic [31:0]     tlp_cnt;
    logic            busy;

    pcie_tx_arbiter #(.NREQ(N), .DATA_W(64), .KEEP_W(8), .BUF_AV_MIN(2)) dut (
        .user_clk         (clk),
        .sys_rst_n        (sys_rst_n),
        .req_tdata        (req_tdata),
        .req_tkeep        (req_tkeep),
        .req_tlast        (req_tlast),
        .req_tuser        (req_tuser),
        .req_tvalid       (req_tvalid),
        .req_tready       (req_tready),
        .s_axis_tx_tdata  (s_axis_tx_tdata),
        .s_axis_tx_tkeep  (s_axis_tx_tkeep),
        .s_axis_tx_tlast  (s_axis_tx_tlast),
        .s_axis_tx_tuser  (s_axis_tx_tuser),
        .s_axis_tx_tvalid (s_axis_tx_tvalid),
        .s_axis_tx_tready (s_axis_tx_tready),
        .tx_buf_av        (tx_buf_av),
        .tx_cfg_req       (tx_cfg_req),
        .tx_cfg_gnt       (tx_cfg_gnt),
        .tlp_cnt          (tlp_cnt),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Requester sources: pending TLP count, length, current beat, TLP sequence number.
    int pend [N];
    int tlen [N];
    int beat [N];
    int seq  [N];
    logic [N-1:0] fire;
    logic neg_fire_last;
    logic neg_gnt;

    task automatic drive_src();
        for (int i = 0; i < N; i++) begin
            req_tvalid[i]         = (pend[i] > 0);
            req_tlast[i]          = (beat[i] == tlen[i] - 1);
            req_tdata[i*64 +: 64] = {8'(160 + i), 8'(seq[i]), 16'h0, 32'(beat[i])};
            req_tkeep[i*8 +: 8]   = req_tlast[i] ? 8'h0F : 8'hFF;
            req_tuser[i*4 +: 4]   = 4'(seq[i] * 2 + i);
        end
    endtask

    task automatic step();
        @(negedge clk);
        neg_fire_last = s_axis_tx_tvalid & s_axis_tx_tready & s_axis_tx_tlast;
        neg_gnt       = tx_cfg_gnt;
        fire          = req_tvalid & req_tready & {N{sys_rst_n}};
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (fire[i]) begin
                if (beat[i] == tlen[i] - 1) begin
                    beat[i] = 0;
                    pend[i] = pend[i] - 1;
                    seq[i]  = seq[i] + 1;
                end else begin
                    beat[i] = beat[i] + 1;
                end
            end
        end
        drive_src();
    endtask

    // Reference model: who owns the port, round-robin start point, completed count.
    int   m_phase = 0;   // 0 idle, 1 config slot, 2 streaming a TLP
    int   m_own   = 0;
    int   m_rr    = 0;
    int   m_cnt   = 0;
    int   glog[$];
    logic chk_en  = 1'b0;

    always @(posedge clk) begin
        if (!sys_rst_n) begin
            m_phase = 0;
            m_own   = 0;
            m_rr    = 0;
            m_cnt   = 0;
        end else if (m_phase == 0) begin
            if (tx_cfg_req) begin
                m_phase = 1;
            end else if (req_tvalid != 0 && tx_buf_av >= 2) begin
                for (int k = N - 1; k >= 0; k--) begin
                    if (req_tvalid[(m_rr + k) % N]) m_own = (m_rr + k) % N;
                end
                glog.push_back(m_own);
                m_phase = 2;
            end
        end else if (m_phase == 1) begin
            if (!tx_cfg_req) m_phase = 0;
        end else begin
            if (req_tvalid[m_own] && s_axis_tx_tready && req_tlast[m_own]) begin
                m_cnt   = m_cnt + 1;
                m_rr    = (m_own + 1) % N;
                m_phase = 0;
            end
        end
        chk_en = 1'b1;
    end

    // Per-cycle compare plus capture of accepted beats.
    logic [63:0] cap[$];
    logic        cap_en   = 1'b0;
    logic        rdy0_seen = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_busy", busy, m_phase == 2);
            check("cyc_cfg_gnt", tx_cfg_gnt, m_phase == 1);
            check("cyc_tvalid", s_axis_tx_tvalid, (m_phase == 2) ? req_tvalid[m_own] : 1'b0);
            check("cyc_tdata", s_axis_tx_tdata, (m_phase == 2) ? req_tdata[m_own*64 +: 64] : 64'h0);
            check("cyc_tkeep", s_axis_tx_tkeep, (m_phase == 2) ? req_tkeep[m_own*8 +: 8] : 8'h0);
            check("cyc_tlast", s_axis_tx_tlast, (m_phase == 2) ? req_tlast[m_own] : 1'b0);
            check("cyc_tuser", s_axis_tx_tuser, (m_phase == 2) ? req_tuser[m_own*4 +: 4] : 4'h0);
            check("cyc_req_tready", req_tready,
                  (m_phase == 2) ? (N'(s_axis_tx_tready) << m_own) : N'(0));
            check("cyc_tlp_cnt", tlp_cnt, m_cnt);
        end
        if (cap_en && s_axis_tx_tvalid && s_axis_tx_tready) cap.push_back(s_axis_tx_tdata);
        if (cap_en && req_tready[0]) rdy0_seen = 1'b1;
    end

    int n;
    int t_end;
    int t_gnt;
    int bp_pat[6] = '{1, 0, 0, 1, 1, 1};
    int cont_exp[4] = '{0, 1, 0, 1};

    initial begin
        sys_rst_n        = 1'b0;
        s_axis_tx_tready = 1'b1;
        tx_buf_av        = 6'd8;
        tx_cfg_req       = 1'b0;
        for (int i = 0; i < N; i++) begin
            pend[i] = 2;
            tlen[i] = 3;
            beat[i] = 0;
            seq[i]  = 0;
        end
        drive_src();

        // Long reset with both requesters valid.
        repeat (100) step();
        check("rst_busy", busy, 0);
        check("rst_tvalid", s_axis_tx_tvalid, 0);
        check("rst_req_tready", req_tready, 0);
        check("rst_tlp_cnt", tlp_cnt, 0);

        // Contention: two 3-beat TLPs each, expect 0,1,0,1 over 16 cycles.
        sys_rst_n = 1'b1;
        n = 0;
        while (tlp_cnt != 4 && n < 200) begin
            step();
            n++;
        end
        check("cont_cycles", n, 16);
        check("cont_tlp_cnt", tlp_cnt, 4);
        check("cont_glog_size", glog.size(), 4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("cont_grant_%0d", k), (glog.size() > k) ? glog[k] : 99, cont_exp[k]);
        end
        step();

        // Backpressure on a 4-beat TLP from req1.
        tlen[1] = 4;
        pend[1] = 1;
        drive_src();
        cap.delete();
        cap_en = 1'b1;
        step();
        for (int k = 0; k < 6; k++) begin
            s_axis_tx_tready = bp_pat[k][0];
            step();
        end
        s_axis_tx_tready = 1'b1;
        step();
        cap_en = 1'b0;
        check("bp_beats", cap.size(), 4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("bp_beat_%0d", k), (cap.size() > k) ? cap[k] : 64'hDEAD,
                  64'hA102_0000_0000_0000 + 64'(k));
        end
        check("bp_req0_tready", rdy0_seen, 0);

        // Buffer gate.
        tx_buf_av = 6'd1;
        tlen[0] = 2;
        pend[0] = 1;
        drive_src();
        repeat (10) step();
        check("gate_hold_busy", busy, 0);
        tx_buf_av = 6'd2;
        step();
        check("gate_go_busy", busy, 1);
        repeat (3) step();
        tx_buf_av = 6'd8;

        // Config request during a TLP waits for tlast plus the bubble.
        tlen[0] = 4;
        pend[0] = 1;
        drive_src();
        step();
        step();
        tx_cfg_req = 1'b1;
        n = 0;
        t_end = -1;
        t_gnt = -1;
        while (n < 20 && t_gnt < 0) begin
            step();
            n++;
            if (neg_fire_last && t_end < 0) t_end = n;
            if (neg_gnt && t_gnt < 0) t_gnt = n;
        end
        check("cfg_mid_seen", (t_end > 0) && (t_gnt > 0), 1);
        check("cfg_mid_delay", t_gnt - t_end, 2);
        tx_cfg_req = 1'b0;
        step();
        step();
        check("cfg_release", tx_cfg_gnt, 0);

        // Config and a requester together in IDLE: config first.
        tx_cfg_req = 1'b1;
        tlen[0] = 2;
        pend[0] = 1;
        drive_src();
        step();
        check("cfg_first_gnt", tx_cfg_gnt, 1);
        check("cfg_first_busy", busy, 0);
        repeat (3) step();
        tx_cfg_req = 1'b0;
        step();
        step();
        check("cfg_then_req_busy", busy, 1);
        check("cfg_then_req_grant", (glog.size() > 0) ? glog[glog.size()-1] : 99, 0);
        check("cfg_then_req_glog", glog.size(), 8);
        repeat (3) step();
        check("pre_rst_tlp_cnt", tlp_cnt, 8);

        // Reset in the middle of a 4-beat TLP.
        tlen[0] = 4;
        pend[0] = 1;
        drive_src();
        step();
        step();
        sys_rst_n = 1'b0;
        step();
        check("rst_mid_tvalid", s_axis_tx_tvalid, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_tlp_cnt", tlp_cnt, 0);
        for (int i = 0; i < N; i++) begin
            pend[i] = 0;
            beat[i] = 0;
        end
        drive_src();
        step();
        sys_rst_n = 1'b1;
        repeat (3) step();
        check("post_rst_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
